// File: rtl/bus_grant_arbiter.sv
// bus_grant_arbiter: round-robin one-hot bus grant with lock and bounded-hold preemption.
module bus_grant_arbiter #(
  parameter int N        = 8,
  parameter int IDW      = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_i,
  input  logic           lock_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] gnt_id_o,
  output logic           gnt_vld_o,
  output logic           preempt_o
);
  typedef enum logic {IDLE, OWNED} state_e;
  state_e         state_q;
  logic [N-1:0]   gnt_q;
  logic [IDW-1:0] gnt_id_q;
  logic [IDW-1:0] ptr_q;
  logic [3:0]     hold_q;
  logic           preempt_q;
  logic [N-1:0]   cand;
  logic [2*N-1:0] dbl;
  logic [IDW:0]   sum;
  logic [IDW-1:0] win;
  logic           any;
  logic           owned;
  logic           owner_req;
  logic           hold_sat;
  logic           take;
  logic           to_idle;
  logic           preempt_d;
  // The owner is masked out, so a release or preemption never regrants it.
  always_comb begin
    owned = state_q == OWNED;
    cand  = owned ? req_i & ~gnt_q : req_i;
    dbl   = {cand, cand} >> ptr_q;
    sum   = '0;
    any   = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (dbl[j]) begin
        sum = {1'b0, ptr_q} + (IDW+1)'(j);
        any = 1'b1;
      end
    end
    win       = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N)) : IDW'(sum);
    owner_req = |(req_i & gnt_q);
    hold_sat  = hold_q == 4'(MAX_HOLD);
    preempt_d = owned && owner_req && !lock_i && hold_sat && any;
    take      = owned ? ((!owner_req && any) || preempt_d) : any;
    to_idle   = owned && !owner_req && !any;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= preempt_d;
      if (take) begin
        state_q  <= OWNED;
        gnt_q    <= N'(1) << win;
        gnt_id_q <= win;
        ptr_q    <= (win == IDW'(N - 1)) ? '0 : win + 1'b1;
        hold_q   <= 4'd1;
      end else if (to_idle) begin
        state_q  <= IDLE;
        gnt_q    <= '0;
        gnt_id_q <= '0;
        hold_q   <= '0;
      end else if (owned) begin
        hold_q <= hold_sat ? hold_q : hold_q + 4'd1;
      end
    end
  end
  assign gnt_o     = gnt_q;
  assign gnt_id_o  = gnt_id_q;
  assign gnt_vld_o = state_q == OWNED;
  assign preempt_o = preempt_q;
endmodule

// File: tb/tb_bus_grant_arbiter.sv
// tb_bus_grant_arbiter: directed scenario tasks with hand-computed grant sequences.
module tb_bus_grant_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic       lock = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_vld;
  logic       preempt;
  int total = 0;
  int bad = 0;

  bus_grant_arbiter #(.N(8), .IDW(3), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .lock_i(lock),
    .gnt_o(gnt), .gnt_id_o(gnt_id), .gnt_vld_o(gnt_vld), .preempt_o(preempt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    total++;
    if (!$onehot0(gnt) || gnt_vld !== (|gnt)) begin
      bad++;
      $display("FAIL invariant gnt=%h gnt_vld=%b", gnt, gnt_vld);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = 8'hFF;
    lock = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    total += 4;
    if (gnt !== 8'h00) begin bad++; $display("FAIL rst_gnt got=%h exp=00", gnt); end
    if (gnt_id !== 3'd0) begin bad++; $display("FAIL rst_id got=%0d exp=0", gnt_id); end
    if (gnt_vld !== 1'b0) begin bad++; $display("FAIL rst_vld got=%b exp=0", gnt_vld); end
    if (preempt !== 1'b0) begin bad++; $display("FAIL rst_pre got=%b exp=0", preempt); end
    #2 rst_n = 1'b1;
    tick();
    total += 3;
    if (gnt !== 8'h01) begin bad++; $display("FAIL rst_first_gnt got=%h exp=01", gnt); end
    if (gnt_id !== 3'd0) begin bad++; $display("FAIL rst_first_id got=%0d exp=0", gnt_id); end
    if (gnt_vld !== 1'b1) begin bad++; $display("FAIL rst_first_vld got=%b exp=1", gnt_vld); end
    for (int k = 2; k <= 6; k++) begin
      logic [7:0] eg;
      logic       ep;
      tick();
      eg = (k <= 4) ? 8'h01 : 8'h02;
      ep = (k == 5);
      total += 2;
      if (gnt !== eg) begin bad++; $display("FAIL rst_seq%0d_gnt got=%h exp=%h", k, gnt, eg); end
      if (preempt !== ep) begin bad++; $display("FAIL rst_seq%0d_pre got=%b exp=%b", k, preempt, ep); end
    end
  endtask

  task automatic test_rotation();
    req = 8'h05;
    lock = 1'b0;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      logic [7:0] eg;
      logic       ep;
      tick();
      eg = (((k - 1) / 4) % 2 == 1) ? 8'h04 : 8'h01;
      ep = (k > 1) && ((k - 1) % 4 == 0);
      total += 2;
      if (gnt !== eg) begin bad++; $display("FAIL rot%0d_gnt got=%h exp=%h", k, gnt, eg); end
      if (preempt !== ep) begin bad++; $display("FAIL rot%0d_pre got=%b exp=%b", k, preempt, ep); end
    end
  endtask

  task automatic test_lock();
    req = 8'h04;
    lock = 1'b0;
    do_reset();
    tick();
    total++;
    if (gnt !== 8'h04) begin bad++; $display("FAIL lock_start got=%h exp=04", gnt); end
    req = 8'h0F;
    lock = 1'b1;
    for (int k = 2; k <= 6; k++) begin
      tick();
      total += 2;
      if (gnt !== 8'h04) begin bad++; $display("FAIL lock%0d_gnt got=%h exp=04", k, gnt); end
      if (preempt !== 1'b0) begin bad++; $display("FAIL lock%0d_pre got=%b exp=0", k, preempt); end
    end
    lock = 1'b0;
    tick();
    total += 3;
    if (gnt !== 8'h08) begin bad++; $display("FAIL lock_drop_gnt got=%h exp=08", gnt); end
    if (gnt_id !== 3'd3) begin bad++; $display("FAIL lock_drop_id got=%0d exp=3", gnt_id); end
    if (preempt !== 1'b1) begin bad++; $display("FAIL lock_drop_pre got=%b exp=1", preempt); end
  endtask

  task automatic test_release();
    req = 8'h20;
    tick();
    total += 4;
    if (gnt !== 8'h20) begin bad++; $display("FAIL rel_gnt got=%h exp=20", gnt); end
    if (gnt_id !== 3'd5) begin bad++; $display("FAIL rel_id got=%0d exp=5", gnt_id); end
    if (gnt_vld !== 1'b1) begin bad++; $display("FAIL rel_vld got=%b exp=1", gnt_vld); end
    if (preempt !== 1'b0) begin bad++; $display("FAIL rel_pre got=%b exp=0", preempt); end
    req = 8'h00;
    tick();
    total += 3;
    if (gnt !== 8'h00) begin bad++; $display("FAIL idle_gnt got=%h exp=00", gnt); end
    if (gnt_vld !== 1'b0) begin bad++; $display("FAIL idle_vld got=%b exp=0", gnt_vld); end
    if (gnt_id !== 3'd0) begin bad++; $display("FAIL idle_id got=%0d exp=0", gnt_id); end
  endtask

  task automatic test_sole();
    req = 8'h80;
    lock = 1'b0;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      tick();
      total += 2;
      if (gnt !== 8'h80) begin bad++; $display("FAIL sole%0d_gnt got=%h exp=80", k, gnt); end
      if (preempt !== 1'b0) begin bad++; $display("FAIL sole%0d_pre got=%b exp=0", k, preempt); end
    end
    req = 8'h81;
    tick();
    total += 2;
    if (gnt !== 8'h01) begin bad++; $display("FAIL sole_add_gnt got=%h exp=01", gnt); end
    if (preempt !== 1'b1) begin bad++; $display("FAIL sole_add_pre got=%b exp=1", preempt); end
  endtask

  task automatic test_async_reset();
    req = 8'h83;
    tick();
    #2 rst_n = 1'b0;
    #1;
    total += 4;
    if (gnt !== 8'h00) begin bad++; $display("FAIL arst_gnt got=%h exp=00", gnt); end
    if (gnt_vld !== 1'b0) begin bad++; $display("FAIL arst_vld got=%b exp=0", gnt_vld); end
    if (gnt_id !== 3'd0) begin bad++; $display("FAIL arst_id got=%0d exp=0", gnt_id); end
    if (preempt !== 1'b0) begin bad++; $display("FAIL arst_pre got=%b exp=0", preempt); end
    tick();
    #2 rst_n = 1'b1;
    tick();
    total += 2;
    if (gnt !== 8'h01) begin bad++; $display("FAIL arst_first_gnt got=%h exp=01", gnt); end
    if (gnt_id !== 3'd0) begin bad++; $display("FAIL arst_first_id got=%0d exp=0", gnt_id); end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_lock();
    test_release();
    test_sole();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_grant_arbiter.md
# bus_grant_arbiter

Round-robin arbiter that decides which source drives the shared 32-bit CPU bus each cycle. It takes bus-drive requests from up to N sources (PC, IR, MDR, IP, C-sign, register file ports, ...) and produces a registered one-hot grant. The grant bits connect directly to the bus mux output-enables (pco, iro, mdro, ...), so at most one source ever drives the bus. Ownership can be locked for multi-cycle transfers and is forcibly rotated after a bounded hold time.

## Interface
- N, 8, number of requesters (2..16)
- IDW, 3, width of gnt_id, equal to ceil(log2(N))
- MAX_HOLD, 4, grant cycles before an unlocked owner can be preempted (1..15)

- clk  input  1  bus clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  N  per-source request to drive the bus; level-sensitive
- lock  input  1  current owner asks to keep the bus; ignored while gnt_vld=0
- gnt  output  N  registered one-hot grant, or all zero; drives the bus mux enables
- gnt_id  output  IDW  binary index of the granted source; 0 when gnt_vld=0
- gnt_vld  output  1  high when exactly one gnt bit is set
- preempt  output  1  one-cycle pulse in the first cycle after a forced handoff

## Operation
- Reset values: gnt=0, gnt_id=0, gnt_vld=0, preempt=0, internal pointer ptr=0, hold_cnt=0.
- Two states:
  - IDLE: gnt_vld=0.
  - OWNED: gnt_vld=1, owner o=gnt_id.
- Winner search: the first set req bit, scanning circularly from index ptr upward and wrapping at N-1 to 0.
- When a grant is issued to source w: ptr becomes (w+1) mod N and hold_cnt becomes 1.
- IDLE, any req set: go to OWNED with winner w.
- IDLE, req=0: stay in IDLE.
- OWNED: at each edge, evaluate in priority order:
  1. req[o]=0 (release): if any other req is set, grant the winner from ptr with no idle gap. Otherwise go to IDLE with gnt=0. A released owner is never regranted in the same decision.
  2. lock=1: keep o. hold_cnt increments, saturating at MAX_HOLD.
  3. hold_cnt=MAX_HOLD and some req[j] with j≠o is set: grant the winner from ptr, excluding o, and pulse preempt.
  4. Otherwise keep o. hold_cnt increments, saturating.
- Sole requester: keeps the grant indefinitely. No preempt, because rule 3 requires another request.
- Requests for indices ≥ N do not exist. ptr wraps modulo N, so for non-power-of-2 N it stays below N.
- Invariant: gnt is $onehot0 at all times, and gnt_vld equals |gnt.

## Timing
- Request-to-grant latency is 1 cycle: req sampled at edge k produces gnt valid after edge k.
- Handoffs are back-to-back: the old owner's bit and the new owner's bit change on the same edge. No overlap, no dead cycle.
- A requester dropping req sees its gnt deasserted after the next edge. Sources must tolerate driving for one cycle after dropping req.
- lock is sampled only at edges where gnt_vld=1. If lock drops while hold_cnt=MAX_HOLD and others are waiting, handoff occurs at the next edge.
- preempt is high exactly in the cycle the new grant is first visible.
- Reset assertion mid-grant clears all outputs immediately, without waiting for clk. The first grant after rst_n deasserts comes one edge after deassertion.

## Test plan
- Reset with req=8'hFF held: outputs are 0 while rst_n=0. After the first edge post-release: gnt=8'h01, gnt_id=0. After 4 cycles: gnt=8'h02, and preempt pulses.
- Rotation: req=8'b0000_0101 steady, lock=0. Expected sequence: gnt=01 for 4 cycles, then 04 for 4, then 01, with preempt at each switch.
- Lock: owner 2 holds lock=1 while req=8'h0F. Grant stays 8'h04 for 6 cycles. Drop lock at cycle 6: the next edge gives gnt=8'h08.
- Release handoff: owner 3 drops req while req[5]=1. The next edge gives gnt=8'h20 with no zero cycle and preempt=0. Then all req drop: the next edge gives gnt=0, gnt_vld=0.
- Sole requester: req=8'h80 for 20 cycles. gnt stays 8'h80 and preempt stays 0. Then add req[0]: gnt switches to 8'h01 within 1 edge if hold_cnt is saturated.
- Async reset mid-grant: assert rst_n=0 between edges. gnt, gnt_vld, and gnt_id go to 0 before the next edge. ptr is back at 0, checked by the first grant after release going to the lowest set req.
